// File: rtl/toggle_activity_monitor.sv
// Switching-activity monitor: per-channel saturating toggle counters over a window
// of enabled cycles. Each window is snapshotted and streamed out one channel per beat.
module toggle_activity_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [NUM_CH-1:0] sig,
  input  logic              clr_overrun,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_ch,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic              overrun
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state_q;
  logic [NUM_CH-1:0]  sig_q;
  logic               primed_q;
  logic [NUM_CH-1:0]  toggle;
  logic [CNT_W-1:0]   cnt_q    [NUM_CH];
  logic [CNT_W-1:0]   cnt_d    [NUM_CH];
  logic [CNT_W-1:0]   shadow_q [NUM_CH];
  logic [WIN_W-1:0]   win_cnt_q;
  logic [WIN_W-1:0]   win_cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_nxt;
  logic               out_valid_q;
  logic [IDX_W-1:0]   out_ch_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_last_q;
  logic               overrun_q;
  logic               close;
  logic               last_hs;
  logic               bank_free;
  logic               accept;
  logic               drop;

  always_comb begin
    toggle = (sig ^ sig_q) & {NUM_CH{primed_q}};
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = (toggle[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  end

  always_comb begin
    close     = en && (win_len != '0) && (win_cnt_q >= win_len - WIN_W'(1));
    win_cnt_d = win_cnt_q;
    if (en) begin
      win_cnt_d = ((win_len == '0) || close) ? '0 : win_cnt_q + WIN_W'(1);
    end
    // The final accepted beat frees the bank in the same cycle, so a close there is not a drop.
    last_hs   = (state_q == S_SEND) && (idx_q == LAST_IDX) && out_valid_q && out_ready;
    bank_free = (state_q == S_IDLE) || last_hs;
    accept    = close && bank_free;
    drop      = close && !bank_free;
    idx_nxt   = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sig_q       <= '0;
      primed_q    <= 1'b0;
      win_cnt_q   <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      sig_q     <= sig;
      primed_q  <= 1'b1;
      win_cnt_q <= win_cnt_d;

      for (int i = 0; i < NUM_CH; i++) begin
        if (close) begin
          cnt_q[i] <= '0;
        end else if (en) begin
          cnt_q[i] <= cnt_d[i];
        end
        if (accept) begin
          shadow_q[i] <= cnt_d[i];
        end
      end

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_SEND;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_ch_q    <= '0;
            out_count_q <= cnt_d[0];
            out_last_q  <= (NUM_CH == 1);
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              if (accept) begin
                idx_q       <= '0;
                out_ch_q    <= '0;
                out_count_q <= cnt_d[0];
                out_last_q  <= (NUM_CH == 1);
              end else begin
                state_q     <= S_IDLE;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
                out_ch_q    <= '0;
                out_count_q <= '0;
                out_last_q  <= 1'b0;
              end
            end else begin
              idx_q       <= idx_nxt;
              out_ch_q    <= idx_nxt;
              out_count_q <= shadow_q[idx_nxt];
              out_last_q  <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: directed vector table, hand sequences for
// multi-cycle corners, and random stimulus checked against a beat-queue scoreboard.
module tb_toggle_activity_monitor;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int WW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [WW-1:0]  win_len = '0;
  logic [NCH-1:0] sig = '0;
  logic           clr_overrun = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [1:0]     out_ch;
  logic [CW-1:0]  out_count;
  logic           out_last;
  logic           overrun;

  int checks = 0;
  int failures = 0;
  bit sb_on = 0;

  toggle_activity_monitor #(.NUM_CH(NCH), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .sig(sig),
    .clr_overrun(clr_overrun), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_count(out_count), .out_last(out_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: unbounded per-window toggle totals, and a queue of pending beats.
  int m_live[NCH];
  int m_wpos = 0;
  logic [NCH-1:0] m_prev = '0;
  bit m_primed = 0;
  bit m_ovr = 0;
  int q_ch[$];
  int q_cnt[$];
  bit m_hs, m_cl;
  int m_wl;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) m_live[i] = 0;
      m_wpos = 0; m_prev = '0; m_primed = 0; m_ovr = 0;
      q_ch.delete(); q_cnt.delete();
    end else begin
      m_wl = int'(win_len);
      m_hs = (q_ch.size() > 0) && out_ready;
      if (en) for (int i = 0; i < NCH; i++) if (m_primed && sig[i] != m_prev[i]) m_live[i]++;
      m_cl = en && (m_wl != 0) && (m_wpos >= m_wl - 1);
      if (en) m_wpos = (m_wl == 0 || m_cl) ? 0 : m_wpos + 1;
      if (m_hs) begin void'(q_ch.pop_front()); void'(q_cnt.pop_front()); end
      if (m_cl && q_ch.size() != 0) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      if (m_cl) begin
        if (q_ch.size() == 0)
          for (int i = 0; i < NCH; i++) begin
            q_ch.push_back(i);
            q_cnt.push_back(m_live[i] > CMAX ? CMAX : m_live[i]);
          end
        for (int i = 0; i < NCH; i++) m_live[i] = 0;
      end
      m_prev = sig; m_primed = 1;
    end
  end

  always @(negedge clk) begin
    if (sb_on && !rst) begin
      chk("sb_valid", int'(out_valid), (q_ch.size() > 0) ? 1 : 0);
      chk("sb_overrun", int'(overrun), int'(m_ovr));
      if (q_ch.size() > 0 && out_valid) begin
        chk("sb_ch", int'(out_ch), q_ch[0]);
        chk("sb_count", int'(out_count), q_cnt[0]);
        chk("sb_last", int'(out_last), (q_ch[0] == NCH - 1) ? 1 : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_on = 1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_last", int'(out_last), 0);
  endtask

  typedef struct {
    int wl; int en0; int init;
    int p0; int p1; int p2; int p3;
    int flip2;
    int e0; int e1; int e2; int e3;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int vi, input vec_t v);
    int per[4];
    int ex[4];
    int last;
    per = '{v.p0, v.p1, v.p2, v.p3};
    ex  = '{v.e0, v.e1, v.e2, v.e3};
    clr_overrun = 1'b0;
    out_ready = 1'b1;
    win_len = WW'(v.wl);
    sig = NCH'(v.init);
    en = (v.en0 != 0);
    do_reset();
    step();
    en = 1'b1;
    last = (v.en0 != 0) ? v.wl - 1 : v.wl;
    for (int k = 1; k <= last; k++) begin
      for (int i = 0; i < NCH; i++)
        if (per[i] != 0 && (k % per[i]) == 0) sig[i] = ~sig[i];
      if (k == v.flip2) sig[2] = ~sig[2];
      step();
    end
    for (int b = 0; b < NCH; b++) begin
      chk($sformatf("v%0d_valid%0d", vi, b), int'(out_valid), 1);
      chk($sformatf("v%0d_ch%0d", vi, b), int'(out_ch), b);
      chk($sformatf("v%0d_cnt%0d", vi, b), int'(out_count), ex[b]);
      chk($sformatf("v%0d_last%0d", vi, b), int'(out_last), (b == NCH - 1) ? 1 : 0);
      step();
    end
  endtask

  initial begin
    int exa[4];
    vecs[0] = '{8,  0, 0,  1, 2, 0, 0, 0, 8, 4, 0, 0};
    vecs[1] = '{40, 0, 0,  1, 2, 5, 3, 0, 15, 15, 8, 13};
    vecs[2] = '{6,  0, 0,  3, 0, 1, 4, 0, 2, 0, 6, 1};
    vecs[3] = '{1,  0, 0,  1, 1, 0, 2, 0, 1, 1, 0, 0};
    vecs[4] = '{8,  1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{8,  1, 15, 0, 0, 0, 0, 3, 0, 0, 1, 0};
    vecs[6] = '{6,  1, 0,  1, 0, 0, 0, 0, 5, 0, 0, 0};

    #2;
    for (int vi = 0; vi < 7; vi++) run_vec(vi, vecs[vi]);

    // Stalled consumer: first snapshot held, second close dropped.
    sig = '0; win_len = 8'd4; out_ready = 1'b0; en = 1'b0; clr_overrun = 1'b0;
    do_reset();
    step();
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      sig[0] = ~sig[0];
      if (k % 2 == 0) sig[1] = ~sig[1];
      step();
      if (k >= 4) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_ch", int'(out_ch), 0);
        chk("stall_cnt", int'(out_count), 4);
      end
      if (k == 7) chk("stall_no_ovr", int'(overrun), 0);
      if (k == 8) chk("stall_ovr", int'(overrun), 1);
    end
    en = 1'b0;
    out_ready = 1'b1;
    exa = '{4, 2, 0, 0};
    for (int b = 0; b < NCH; b++) begin
      chk("drain_ch", int'(out_ch), b);
      chk("drain_cnt", int'(out_count), exa[b]);
      step();
    end
    chk("drain_idle", int'(out_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clr", int'(overrun), 0);

    // Final handshake on the same edge as the next close.
    sig = '0; win_len = 8'd4; out_ready = 1'b1; en = 1'b0;
    do_reset();
    step();
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      sig[0] = ~sig[0];
      if (k >= 5) sig[2] = ~sig[2];
      step();
      if (k == 4) chk("b2b_first_cnt", int'(out_count), 4);
      if (k == 8) begin
        chk("b2b_ovr", int'(overrun), 0);
        chk("b2b_valid", int'(out_valid), 1);
        chk("b2b_ch", int'(out_ch), 0);
        chk("b2b_cnt0", int'(out_count), 4);
      end
      if (k == 10) begin
        chk("b2b_ch2", int'(out_ch), 2);
        chk("b2b_cnt2", int'(out_count), 4);
      end
    end

    // en gap mid-window, then reset during readout.
    sig = '0; win_len = 8'd8; out_ready = 1'b1; en = 1'b0;
    do_reset();
    step();
    for (int k = 1; k <= 13; k++) begin
      en = !(k >= 4 && k <= 8);
      sig[0] = ~sig[0];
      step();
      if (k == 12) chk("gap_not_yet", int'(out_valid), 0);
      if (k == 13) begin
        chk("gap_valid", int'(out_valid), 1);
        chk("gap_cnt", int'(out_count), 8);
      end
    end
    step();
    chk("gap_ch1", int'(out_ch), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ch", int'(out_ch), 0);
    chk("mid_rst_cnt", int'(out_count), 0);
    chk("mid_rst_last", int'(out_last), 0);
    chk("mid_rst_ovr", int'(overrun), 0);

    // Random traffic against the scoreboard.
    en = 1'b1; sig = '0; out_ready = 1'b1; win_len = 8'd5;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) win_len = ($urandom_range(0, 5) == 0) ? 8'd0 : WW'($urandom_range(1, 14));
      en = ($urandom_range(0, 9) < 8);
      sig = sig ^ NCH'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_overrun = ($urandom_range(0, 19) == 0);
      if (c == 2000) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
